// File: rtl/fetch_sequencer.sv
// Fetch sequencer: reads a 6502 opcode, sizes it from its aaa/bbb/cc fields, fetches 0-2 operand bytes, issues to the decoder.
// Define FETCH_WDOG_EN to add a memory-wait watchdog (sticky o_fetch_err, HALT state).
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    REG_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
`ifdef FETCH_WDOG_EN
    ,
    parameter int                    WDOG_LIMIT = 15
`endif
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic [ADDR_WIDTH-1:0]    o_mem_addr,
    output logic                     o_mem_rd,
    input  logic [REG_WIDTH-1:0]     i_mem_rdata,
    input  logic                     i_mem_valid,
    input  logic                     i_get_next,
    input  logic                     i_pc_load,
    input  logic [ADDR_WIDTH-1:0]    i_pc_in,
    output logic [REG_WIDTH-1:0]     o_instruction,
    output logic [2*REG_WIDTH-1:0]   o_operand,
    output logic [1:0]               o_operand_len,
    output logic [ADDR_WIDTH-1:0]    o_instr_addr,
    output logic                     o_instruction_ready,
    output logic [ADDR_WIDTH-1:0]    o_pc,
    output logic                     o_fetch_err
);

    typedef enum logic [3:0] {
        S_FETCH_OP, S_WAIT_OP, S_FETCH_LO, S_WAIT_LO,
        S_FETCH_HI, S_WAIT_HI, S_ISSUE, S_WAIT_NEXT, S_HALT
    } state_t;

    function automatic logic [1:0] f_len(input logic [7:0] op);
        logic [2:0] bbb;
        bbb   = op[4:2];
        f_len = 2'd0;
        case (op[1:0])
            2'b01: f_len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd2 : 2'd1;
            2'b11: f_len = 2'd0;
            default: begin
                case (bbb)
                    3'b000: begin
                        if (op == 8'h00 || op == 8'h40 || op == 8'h60) f_len = 2'd0;
                        else if (op == 8'h20)                          f_len = 2'd2;
                        else                                           f_len = 2'd1;
                    end
                    3'b001, 3'b100, 3'b101: f_len = 2'd1;
                    3'b010, 3'b110:         f_len = 2'd0;
                    default:                f_len = 2'd2;
                endcase
            end
        endcase
    endfunction

    state_t                  r_state, w_next;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [REG_WIDTH-1:0]    r_opcode, r_lo;
    logic [ADDR_WIDTH-1:0]   r_op_addr;
    logic [1:0]              r_len;
    logic [REG_WIDTH-1:0]    r_instruction;
    logic [2*REG_WIDTH-1:0]  r_operand;
    logic [1:0]              r_operand_len;
    logic [ADDR_WIDTH-1:0]   r_instr_addr;

    logic                    w_capture, w_issue, w_fetch, w_wdog_trip;
    logic [1:0]              w_len;
    logic [REG_WIDTH-1:0]    w_iss_instr;
    logic [ADDR_WIDTH-1:0]   w_iss_addr;
    logic [1:0]              w_iss_len;
    logic [2*REG_WIDTH-1:0]  w_iss_operand;

    assign w_len   = f_len(i_mem_rdata[7:0]);
    assign w_fetch = (r_state == S_FETCH_OP) || (r_state == S_FETCH_LO) || (r_state == S_FETCH_HI);

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_FETCH_OP;
        else          r_state <= w_next;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_next        = r_state;
        w_capture     = 1'b0;
        w_issue       = 1'b0;
        w_iss_instr   = r_opcode;
        w_iss_addr    = r_op_addr;
        w_iss_len     = r_len;
        w_iss_operand = '0;
        case (r_state)
            S_FETCH_OP: w_next = S_WAIT_OP;
            S_WAIT_OP: if (i_mem_valid) begin
                w_capture   = 1'b1;
                w_iss_instr = i_mem_rdata;
                w_iss_addr  = r_pc;
                w_iss_len   = w_len;
                w_issue     = (w_len == 2'd0);
                w_next      = w_issue ? S_ISSUE : S_FETCH_LO;
            end
            S_FETCH_LO: w_next = S_WAIT_LO;
            S_WAIT_LO: if (i_mem_valid) begin
                w_capture     = 1'b1;
                w_iss_operand = {{REG_WIDTH{1'b0}}, i_mem_rdata};
                w_issue       = (r_len == 2'd1);
                w_next        = w_issue ? S_ISSUE : S_FETCH_HI;
            end
            S_FETCH_HI: w_next = S_WAIT_HI;
            S_WAIT_HI: if (i_mem_valid) begin
                w_capture     = 1'b1;
                w_iss_operand = {i_mem_rdata, r_lo};
                w_issue       = 1'b1;
                w_next        = S_ISSUE;
            end
            S_ISSUE:     w_next = S_WAIT_NEXT;
            S_WAIT_NEXT: if (i_pc_load || i_get_next) w_next = S_FETCH_OP;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_FETCH_OP;
        endcase
        if (w_wdog_trip) w_next = S_HALT;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_instruction <= '0;
            r_operand     <= '0;
            r_operand_len <= '0;
            r_instr_addr  <= '0;
        end else begin
            if (r_state == S_WAIT_NEXT && i_pc_load) r_pc <= i_pc_in;
            else if (w_capture)                      r_pc <= r_pc + ADDR_WIDTH'(1);
            if (w_issue) begin
                r_instruction <= w_iss_instr;
                r_operand     <= w_iss_operand;
                r_operand_len <= w_iss_len;
                r_instr_addr  <= w_iss_addr;
            end
        end
    end

    // NOTE: capture registers are not reset; each is written by a fetch before anything reads it.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            case (r_state)
                S_WAIT_OP: begin
                    r_opcode  <= i_mem_rdata;
                    r_op_addr <= r_pc;
                    r_len     <= w_len;
                end
                S_WAIT_LO: r_lo <= i_mem_rdata;
                default: ;
            endcase
        end
    end

`ifdef FETCH_WDOG_EN
    localparam int                WDOG_W    = $clog2(WDOG_LIMIT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              r_fetch_err;
    logic              w_wait;

    assign w_wait      = (r_state == S_WAIT_OP) || (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
    // A mem_valid on the limit cycle captures normally instead of tripping.
    assign w_wdog_trip = w_wait && !i_mem_valid && (r_wdog == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wdog      <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (w_fetch)                     r_wdog <= '0;
            else if (w_wait && !i_mem_valid) r_wdog <= r_wdog + WDOG_W'(1);
            if (w_wdog_trip) r_fetch_err <= 1'b1;
        end
    end

    assign o_fetch_err = r_fetch_err;
`else
    assign w_wdog_trip = 1'b0;
    assign o_fetch_err = 1'b0;
`endif

    // Gated by reset_n so no read request escapes while reset is held.
    assign o_mem_rd            = w_fetch && reset_n;
    assign o_mem_addr          = o_mem_rd ? r_pc : '0;
    assign o_instruction_ready = (r_state == S_ISSUE);
    assign o_instruction       = r_instruction;
    assign o_operand           = r_operand;
    assign o_operand_len       = r_operand_len;
    assign o_instr_addr        = r_instr_addr;
    assign o_pc                = r_pc;

endmodule
